mat_cache_streamer: RTL and testbench

MAT_CACHE_STREAMER -- requirements
Module: mat_cache_streamer

---
 rtl/mat_cache_streamer.sv | 184 ++++++++++++++++++
 tb/tb_mat_cache_streamer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_cache_streamer.sv
// mat_cache_streamer: streams WIDTH cache vectors (DIAG/ROW/COL sweep) to a
// valid/ready sink. Optional macro MAT_STREAM_REVERSE_EN adds cmd_reverse.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   cmd_valid/cmd_ready   sweep command handshake
//   cmd_type/addr1/addr2  sweep kind and matrices (addr2 used by DIAG)
//   cmd_reverse           descending sweep (MAT_STREAM_REVERSE_EN only)
//   cache_read_*          read request to the cache, cache_data returns
//   out_valid/out_ready   output vector handshake
//   out_data/index/last   registered vector, its param, end-of-sweep flag
//   busy                  FSM not idle
package mat_cache_pkg;
    typedef enum logic [1:0] {
        DIAG = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2
    } MatCacheReadOp_t;
endpackage

module mat_cache_streamer
    import mat_cache_pkg::*;
#(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH),
    parameter int CACHE_SIZE      = 4,
    parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  MatCacheReadOp_t            cmd_type,
    input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr1,
    input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr2,
`ifdef MAT_STREAM_REVERSE_EN
    input  logic                       cmd_reverse,
`endif
    output MatCacheReadOp_t            cache_read_type,
    output logic [CACHE_ADDR_SIZE-1:0] cache_read_addr1,
    output logic [CACHE_ADDR_SIZE-1:0] cache_read_addr2,
    output logic [WIDTH_ADDR_SIZE-1:0] cache_read_param,
    input  shortreal                   cache_data [WIDTH],
    output logic                       out_valid,
    input  logic                       out_ready,
    output shortreal                   out_data [WIDTH],
    output logic [WIDTH_ADDR_SIZE-1:0] out_index,
    output logic                       out_last,
    output logic                       busy
);

    localparam logic [WIDTH_ADDR_SIZE-1:0] P_MAX = WIDTH_ADDR_SIZE'(WIDTH - 1);
    localparam logic [WIDTH_ADDR_SIZE-1:0] P_ONE = WIDTH_ADDR_SIZE'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    MatCacheReadOp_t              type_q;
    logic [CACHE_ADDR_SIZE-1:0]   addr1_q;
    logic [CACHE_ADDR_SIZE-1:0]   addr2_q;
    logic [WIDTH_ADDR_SIZE-1:0]   param;
    logic [WIDTH_ADDR_SIZE-1:0]   param_start;
    logic [WIDTH_ADDR_SIZE-1:0]   param_next;
    logic                         param_last;
    logic                         accept;
    logic                         load;
    logic                         out_hs;

    assign out_hs = out_valid && out_ready;

`ifdef MAT_STREAM_REVERSE_EN
    logic rev_q;

    assign param_start = cmd_reverse ? P_MAX : '0;
    assign param_last  = rev_q ? (param == '0) : (param == P_MAX);
    assign param_next  = rev_q ? (param - P_ONE) : (param + P_ONE);
`else
    assign param_start = '0;
    assign param_last  = (param == P_MAX);
    assign param_next  = param + P_ONE;
`endif

    assign cache_read_type  = type_q;
    assign cache_read_addr1 = addr1_q;
    assign cache_read_addr2 = addr2_q;
    assign cache_read_param = param;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (load && param_last) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_hs) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        load      = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                accept    = cmd_valid;
            end
            S_RUN: begin
                load = !out_valid || out_ready;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // param saturates on the final vector so it never leaves 0..WIDTH-1
    always_ff @(posedge clock) begin
        if (reset) begin
            type_q    <= DIAG;
            addr1_q   <= '0;
            addr2_q   <= '0;
            param     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                out_data[i] <= 0.0;
            end
`ifdef MAT_STREAM_REVERSE_EN
            rev_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                type_q  <= cmd_type;
                addr1_q <= cmd_addr1;
                addr2_q <= cmd_addr2;
                param   <= param_start;
`ifdef MAT_STREAM_REVERSE_EN
                rev_q   <= cmd_reverse;
`endif
            end
            if (load) begin
                out_data  <= cache_data;
                out_index <= param;
                out_last  <= param_last;
                out_valid <= 1'b1;
                if (!param_last) begin
                    param <= param_next;
                end
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mat_cache_streamer.sv
// tb_mat_cache_streamer: directed sweeps against a combinational cache model;
// expected vectors are queued at command issue and checked by a monitor.
`timescale 1ns/1ps
module tb_mat_cache_streamer;
    import mat_cache_pkg::*;

    localparam int W  = 4;
    localparam int WA = 1 + $clog2(W);
    localparam int CA = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    MatCacheReadOp_t cmd_type = DIAG;
    logic [CA-1:0]   cmd_addr1 = '0;
    logic [CA-1:0]   cmd_addr2 = '0;
`ifdef MAT_STREAM_REVERSE_EN
    logic            cmd_reverse = 1'b0;
`endif
    MatCacheReadOp_t cache_read_type;
    logic [CA-1:0]   cache_read_addr1;
    logic [CA-1:0]   cache_read_addr2;
    logic [WA-1:0]   cache_read_param;
    shortreal        cache_data [W];
    logic            out_valid;
    logic            out_ready = 1'b1;
    shortreal        out_data [W];
    logic [WA-1:0]   out_index;
    logic            out_last;
    logic            busy;

    mat_cache_streamer #(
        .WIDTH(W),
        .CACHE_SIZE(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type(cmd_type),
        .cmd_addr1(cmd_addr1),
        .cmd_addr2(cmd_addr2),
`ifdef MAT_STREAM_REVERSE_EN
        .cmd_reverse(cmd_reverse),
`endif
        .cache_read_type(cache_read_type),
        .cache_read_addr1(cache_read_addr1),
        .cache_read_addr2(cache_read_addr2),
        .cache_read_param(cache_read_param),
        .cache_data(cache_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_index(out_index),
        .out_last(out_last),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]        idx;
        logic               last;
        logic [W-1:0][31:0] data;
    } exp_t;

    exp_t sb [$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_end_cyc = -1;

    always @(posedge clock) cyc++;

    // Matrix m, row r, column c holds m*100 + r*10 + c
    function automatic int mval(int m, int r, int c);
        return m * 100 + r * 10 + c;
    endfunction

    function automatic int cval(MatCacheReadOp_t t, int a1, int a2,
                                int p, int i);
        case (t)
            ROW:     return mval(a1, p, i);
            COL:     return mval(a1, i, p);
            default: return mval(a1, p, i) * 1000 + mval(a2, i, p);
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < W; i++) begin
            cache_data[i] = shortreal'(cval(cache_read_type,
                int'(cache_read_addr1), int'(cache_read_addr2),
                int'(cache_read_param), i));
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    // Monitor: a handshake seen at negedge completes at the next posedge
    always @(negedge clock) begin
        exp_t e;
        if (out_valid && out_ready && !reset) begin
            if (sb.size() == 0) begin
                chk("unexpected_vector_index", int'(out_index), -1);
            end else begin
                e = sb.pop_front();
                chk("out_index", int'(out_index), int'(e.idx));
                chk("out_last", int'(out_last), int'(e.last));
                for (int i = 0; i < W; i++) begin
                    chk($sformatf("out_data[%0d]", i),
                        int'(out_data[i]), int'(e.data[i]));
                end
                if (out_last) last_end_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_sweep(input MatCacheReadOp_t t, input int a1,
                              input int a2, input bit rev);
        exp_t e;
        int   p;
        for (int k = 0; k < W; k++) begin
            p = rev ? (W - 1 - k) : k;
            e.idx  = p;
            e.last = (k == W - 1);
            for (int i = 0; i < W; i++) begin
                e.data[i] = cval(t, a1, a2, p, i);
            end
            sb.push_back(e);
        end
    endtask

    task automatic issue(input MatCacheReadOp_t t, input int a1,
                         input int a2, input bit rev, output int acc);
        cmd_type  = t;
        cmd_addr1 = CA'(a1);
        cmd_addr2 = CA'(a2);
`ifdef MAT_STREAM_REVERSE_EN
        cmd_reverse = rev;
`endif
        cmd_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 50 && acc < 0; n++) begin
            @(negedge clock);
            if (cmd_ready) begin
                acc = cyc;
                push_sweep(t, a1, a2, rev);
            end
            step();
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", int'(acc >= 0), 1);
    endtask

    task automatic wait_done(input bit rd_chk, input MatCacheReadOp_t t,
                             input int a1, input int a2, output int done);
        done = -1;
        for (int n = 0; n < 100 && done < 0; n++) begin
            @(negedge clock);
            if (rd_chk && busy) begin
                chk("rd_type", int'(cache_read_type), int'(t));
                chk("rd_addr1", int'(cache_read_addr1), a1);
                chk("rd_addr2", int'(cache_read_addr2), a2);
            end
            if (sb.size() == 0 && !busy) done = cyc;
        end
        chk("sweep_done", int'(done >= 0), 1);
        step();
    endtask

    task automatic wait_index(input int idx);
        bit seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clock);
            if (out_valid && out_ready && int'(out_index) == idx) seen = 1'b1;
            else step();
        end
        chk($sformatf("reach_index_%0d", idx), int'(seen), 1);
    endtask

    initial begin
        int acc;
        int acc2;
        int done;
        int nacc;

        step();
        step();
        @(negedge clock);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_rd_type", int'(cache_read_type), int'(DIAG));
        chk("rst_rd_param", int'(cache_read_param), 0);
        step();
        reset = 1'b0;
        step();
        chk("idle_cmd_ready", int'(cmd_ready), 1);

        // ROW sweep at full throughput
        issue(ROW, 2, 0, 1'b0, acc);
        wait_done(1'b0, ROW, 0, 0, done);
        chk("row_last_latency", last_end_cyc - acc, W + 1);
        chk("row_cmd_ready_rise", done - last_end_cyc, 1);

        // DIAG sweep, read bus must hold the command throughout
        issue(DIAG, 0, 1, 1'b0, acc);
        wait_done(1'b1, DIAG, 0, 1, done);

        // DIAG with both addresses equal
        issue(DIAG, 2, 2, 1'b0, acc);
        wait_done(1'b0, DIAG, 2, 2, done);

        // Backpressure for 3 cycles while index 1 is presented
        issue(COL, 3, 0, 1'b0, acc);
        wait_index(0);
        step();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_index", int'(out_index), 1);
            chk("stall_data0", int'(out_data[0]), cval(COL, 3, 0, 1, 0));
            chk("stall_data3", int'(out_data[3]), cval(COL, 3, 0, 1, 3));
        end
        step();
        out_ready = 1'b1;
        wait_done(1'b0, COL, 0, 0, done);

        // Reset mid-sweep after index 1 is accepted
        issue(ROW, 1, 0, 1'b0, acc);
        wait_index(1);
        step();
        reset = 1'b1;
        sb.delete();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
        chk("mid_rst_out_data0", int'(out_data[0]), 0);
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_quiet", int'(out_valid), 0);
        end
        step();

        // cmd_valid held: exactly one more sweep, only after the drain
        cmd_type  = ROW;
        cmd_addr1 = 2'd3;
        cmd_addr2 = 2'd0;
        cmd_valid = 1'b1;
        nacc = 0;
        acc  = -1;
        acc2 = -1;
        for (int n = 0; n < 60 && nacc < 2; n++) begin
            @(negedge clock);
            if (cmd_ready) begin
                nacc++;
                if (nacc == 1) acc = cyc;
                else acc2 = cyc;
                push_sweep(ROW, 3, 0, 1'b0);
            end
            step();
        end
        cmd_valid = 1'b0;
        chk("held_cmd_accepts", nacc, 2);
        chk("held_cmd_gap", acc2 - acc, W + 2);
        wait_done(1'b0, ROW, 0, 0, done);

`ifdef MAT_STREAM_REVERSE_EN
        issue(COL, 1, 0, 1'b1, acc);
        wait_done(1'b0, COL, 0, 0, done);
        chk("rev_last_latency", last_end_cyc - acc, W + 1);
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
